// File: rtl/poly_synth.sv
// ---------------------------------------------------------------------------
// poly_synth
//   Time-multiplexed polyphonic DDS synthesizer. A table of VOICES voices
//   (active, key, phase increment, phase) is swept once per output sample:
//   each active voice contributes one waveform sample derived from the top
//   WIDTH bits of its phase, and the sum is scaled down by VOICES.
//
// Parameters
//   VOICES      number of voices (power of two, >= 2)
//   PHASE_BITS  phase accumulator width (>= WIDTH)
//   WIDTH       signed sample width
//   KEY_BITS    note key width
//
// Ports
//   clk_in           system clock, rising edge
//   n_rst_in         asynchronous active-low reset
//   sample_tick_in   one-cycle pulse at the output sample rate
//   cmd_valid_in     note command valid
//   cmd_ready_out    high while idle; command taken when valid && ready
//   cmd_on_in        1 = note-on, 0 = note-off
//   cmd_key_in       note key
//   cmd_incr_in      phase increment (note-on only)
//   wave_in          0 saw, 1 square, 2 triangle, 3 mute
//   synth_out        signed mixed sample, held between updates
//   synth_valid_out  one-cycle pulse when synth_out updates
//   active_out       per-voice active flags
//   overrun_out      one-cycle pulse after a tick arrived while busy
// ---------------------------------------------------------------------------
module poly_synth #(
    parameter int VOICES     = 4,
    parameter int PHASE_BITS = 24,
    parameter int WIDTH      = 16,
    parameter int KEY_BITS   = 7
) (
    input  logic                      clk_in,
    input  logic                      n_rst_in,
    input  logic                      sample_tick_in,
    input  logic                      cmd_valid_in,
    output logic                      cmd_ready_out,
    input  logic                      cmd_on_in,
    input  logic [KEY_BITS-1:0]       cmd_key_in,
    input  logic [PHASE_BITS-1:0]     cmd_incr_in,
    input  logic [1:0]                wave_in,
    output logic signed [WIDTH-1:0]   synth_out,
    output logic                      synth_valid_out,
    output logic [VOICES-1:0]         active_out,
    output logic                      overrun_out
);

    localparam int VB    = $clog2(VOICES);
    localparam int ACC_W = WIDTH + VB;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                   state;
    logic [VB-1:0]            idx;
    logic [VB-1:0]            steal_ptr;
    logic [1:0]               wave_sel;
    logic signed [ACC_W-1:0]  acc;

    // Voice table
    logic [VOICES-1:0]        active;
    logic [KEY_BITS-1:0]      key   [VOICES];
    logic [PHASE_BITS-1:0]    incr  [VOICES];
    logic [PHASE_BITS-1:0]    phase [VOICES];

    // Command decode
    logic                     accept;
    logic                     hit;
    logic [VB-1:0]            hit_idx;
    logic                     free;
    logic [VB-1:0]            free_idx;
    logic [VB-1:0]            on_idx;
    logic [VOICES-1:0]        off_mask;

    // Waveform generation for the voice currently being visited
    logic [WIDTH-1:0]         p;
    logic [WIDTH-2:0]         t;
    logic signed [WIDTH-1:0]  wave_val;

    assign cmd_ready_out = (state == IDLE);
    assign accept        = cmd_valid_in && cmd_ready_out;
    assign active_out    = active;

    // Lowest-index active key match and lowest-index free voice.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        off_mask = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!hit && active[i] && (key[i] == cmd_key_in)) begin
                hit     = 1'b1;
                hit_idx = VB'(i);
            end
            if (!free && !active[i]) begin
                free     = 1'b1;
                free_idx = VB'(i);
            end
            off_mask[i] = (key[i] == cmd_key_in);
        end
    end

    // Retrigger beats allocation, allocation beats stealing.
    always_comb begin
        on_idx = steal_ptr;
        if (hit) begin
            on_idx = hit_idx;
        end else if (free) begin
            on_idx = free_idx;
        end
    end

    // Subtracting 2^(WIDTH-1) from an unsigned WIDTH-bit value is the same
    // as inverting its MSB and reading it as signed.
    always_comb begin
        p        = phase[idx][PHASE_BITS-1 -: WIDTH];
        t        = p[WIDTH-1] ? ~p[WIDTH-2:0] : p[WIDTH-2:0];
        wave_val = '0;
        case (wave_sel)
            2'd0:    wave_val = {~p[WIDTH-1], p[WIDTH-2:0]};
            2'd1:    wave_val = p[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
            2'd2:    wave_val = {~t[WIDTH-2], t[WIDTH-3:0], 1'b0};
            default: wave_val = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state           <= IDLE;
            idx             <= '0;
            steal_ptr       <= '0;
            wave_sel        <= '0;
            acc             <= '0;
            synth_out       <= '0;
            synth_valid_out <= 1'b0;
            overrun_out     <= 1'b0;
            active          <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                key[i]   <= '0;
                incr[i]  <= '0;
                phase[i] <= '0;
            end
        end else begin
            synth_valid_out <= 1'b0;
            overrun_out     <= sample_tick_in && (state != IDLE);

            // Commands are only taken in IDLE, so they never collide with
            // the phase updates made during ACCUM.
            if (accept) begin
                if (cmd_on_in) begin
                    active[on_idx] <= 1'b1;
                    key[on_idx]    <= cmd_key_in;
                    incr[on_idx]   <= cmd_incr_in;
                    phase[on_idx]  <= '0;
                    if (!hit && !free) begin
                        steal_ptr <= steal_ptr + 1'b1;
                    end
                end else begin
                    active <= active & ~off_mask;
                end
            end

            case (state)
                IDLE: begin
                    if (sample_tick_in) begin
                        wave_sel <= wave_in;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (active[idx]) begin
                        acc        <= acc + {{VB{wave_val[WIDTH-1]}}, wave_val};
                        phase[idx] <= phase[idx] + incr[idx];
                    end
                    idx <= idx + 1'b1;
                    if (idx == VB'(VOICES - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    synth_out       <= WIDTH'(acc >>> VB);
                    synth_valid_out <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
